// File: rtl/mem_req.sv
`default_nettype none
// ============================================================================
// Module      : mem_req
// Description : Memory-request stage. Turns an EX-stage load/store into a
//               word-aligned, lane-masked data-memory request. It holds the
//               request until dmem_resp arrives and then emits one registered
//               completion pulse toward WB. Misaligned or illegal accesses
//               and non-memory instructions complete immediately without
//               touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic [31:0] out_addr,
    output logic [3:0]  out_rmask,
    output logic [3:0]  out_wmask,
    output logic [31:0] out_wdata,
    output logic        out_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_rmask_q, dmem_rmask_d;
    logic [3:0]  dmem_wmask_q, dmem_wmask_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] req_addr_q, req_addr_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_rdata_q, out_rdata_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [3:0]  out_rmask_q, out_rmask_d;
    logic [3:0]  out_wmask_q, out_wmask_d;
    logic [31:0] out_wdata_q, out_wdata_d;
    logic        out_err_q, out_err_d;

    // A memory response and an immediate (non-memory or faulting) completion
    // can land in the same cycle; the younger one waits here for one cycle so
    // that only one completion is emitted per cycle and order is preserved.
    logic        pend_valid_q, pend_valid_d;
    logic        pend_err_q, pend_err_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic        misaligned;
    logic        funct3_ok;
    logic        is_mem;
    logic        is_bad;
    logic        accept;
    logic        resp_fire;
    logic        mem_go;
    logic        imm_go;
    logic        imm_err;

    assign stall     = (state_q == ST_REQ) & ~dmem_resp;
    assign accept    = in_valid & ~stall;
    assign resp_fire = (state_q == ST_REQ) & dmem_resp;

    assign funct3_ok = (in_funct3 == 3'b000) | (in_funct3 == 3'b001) |
                       (in_funct3 == 3'b010) | (in_funct3 == 3'b100) |
                       (in_funct3 == 3'b101);
    assign is_mem    = in_load | in_store;
    assign is_bad    = (in_load & in_store) | ~funct3_ok | misaligned;
    assign mem_go    = accept & is_mem & ~is_bad;
    assign imm_go    = accept & ~mem_go;
    assign imm_err   = is_mem & is_bad;

    // Lane enables, lane-aligned store data and alignment check by access size
    always_comb begin
        lane_mask  = 4'b0000;
        lane_wdata = 32'h0;
        misaligned = 1'b0;
        case (in_funct3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << in_addr[1:0];
                lane_wdata = {24'h0, in_wdata[7:0]} << {in_addr[1:0], 3'b000};
            end
            2'b01: begin
                lane_mask  = in_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = in_addr[1] ? {in_wdata[15:0], 16'h0}
                                        : {16'h0, in_wdata[15:0]};
                misaligned = in_addr[0];
            end
            2'b10: begin
                lane_mask  = 4'b1111;
                lane_wdata = in_wdata;
                misaligned = |in_addr[1:0];
            end
            default: begin
                lane_mask  = 4'b0000;
                lane_wdata = 32'h0;
                misaligned = 1'b0;
            end
        endcase
    end

    // Next-state: request lifecycle, then completion routing (response first,
    // then any parked immediate completion, then a fresh immediate one)
    always_comb begin
        state_d      = state_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_rmask_d = dmem_rmask_q;
        dmem_wmask_d = dmem_wmask_q;
        dmem_wdata_d = dmem_wdata_q;
        req_addr_d   = req_addr_q;
        out_valid_d  = 1'b0;
        out_rdata_d  = out_rdata_q;
        out_addr_d   = out_addr_q;
        out_rmask_d  = out_rmask_q;
        out_wmask_d  = out_wmask_q;
        out_wdata_d  = out_wdata_q;
        out_err_d    = out_err_q;
        pend_valid_d = pend_valid_q;
        pend_err_d   = pend_err_q;
        pend_addr_d  = pend_addr_q;

        if (resp_fire) begin
            state_d      = ST_IDLE;
            dmem_addr_d  = 32'h0;
            dmem_rmask_d = 4'b0000;
            dmem_wmask_d = 4'b0000;
            dmem_wdata_d = 32'h0;
        end

        if (mem_go) begin
            state_d      = ST_REQ;
            dmem_addr_d  = {in_addr[31:2], 2'b00};
            dmem_rmask_d = in_load  ? lane_mask  : 4'b0000;
            dmem_wmask_d = in_store ? lane_mask  : 4'b0000;
            dmem_wdata_d = in_store ? lane_wdata : 32'h0;
            req_addr_d   = in_addr;
        end

        if (resp_fire) begin
            out_valid_d  = 1'b1;
            out_rdata_d  = dmem_rdata;
            out_addr_d   = req_addr_q;
            out_rmask_d  = dmem_rmask_q;
            out_wmask_d  = dmem_wmask_q;
            out_wdata_d  = dmem_wdata_q;
            out_err_d    = 1'b0;
            pend_valid_d = imm_go;
            pend_err_d   = imm_err;
            pend_addr_d  = in_addr;
        end else if (pend_valid_q) begin
            out_valid_d  = 1'b1;
            out_rdata_d  = 32'h0;
            out_addr_d   = pend_addr_q;
            out_rmask_d  = 4'b0000;
            out_wmask_d  = 4'b0000;
            out_wdata_d  = 32'h0;
            out_err_d    = pend_err_q;
            pend_valid_d = imm_go;
            pend_err_d   = imm_err;
            pend_addr_d  = in_addr;
        end else if (imm_go) begin
            out_valid_d  = 1'b1;
            out_rdata_d  = 32'h0;
            out_addr_d   = in_addr;
            out_rmask_d  = 4'b0000;
            out_wmask_d  = 4'b0000;
            out_wdata_d  = 32'h0;
            out_err_d    = imm_err;
        end
    end

    // State and output registers; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            dmem_addr_q  <= 32'h0;
            dmem_rmask_q <= 4'b0000;
            dmem_wmask_q <= 4'b0000;
            dmem_wdata_q <= 32'h0;
            req_addr_q   <= 32'h0;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= 32'h0;
            out_addr_q   <= 32'h0;
            out_rmask_q  <= 4'b0000;
            out_wmask_q  <= 4'b0000;
            out_wdata_q  <= 32'h0;
            out_err_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_err_q   <= 1'b0;
            pend_addr_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_rmask_q <= dmem_rmask_d;
            dmem_wmask_q <= dmem_wmask_d;
            dmem_wdata_q <= dmem_wdata_d;
            req_addr_q   <= req_addr_d;
            out_valid_q  <= out_valid_d;
            out_rdata_q  <= out_rdata_d;
            out_addr_q   <= out_addr_d;
            out_rmask_q  <= out_rmask_d;
            out_wmask_q  <= out_wmask_d;
            out_wdata_q  <= out_wdata_d;
            out_err_q    <= out_err_d;
            pend_valid_q <= pend_valid_d;
            pend_err_q   <= pend_err_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign dmem_addr  = dmem_addr_q;
    assign dmem_rmask = dmem_rmask_q;
    assign dmem_wmask = dmem_wmask_q;
    assign dmem_wdata = dmem_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_rdata  = out_rdata_q;
    assign out_addr   = out_addr_q;
    assign out_rmask  = out_rmask_q;
    assign out_wmask  = out_wmask_q;
    assign out_wdata  = out_wdata_q;
    assign out_err    = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req
// Description : Self-checking bench for mem_req: directed scenarios followed
//               by random traffic, all checked against a transaction-level
//               reference model with an in-order completion queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_load, in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;
    logic        stall, out_valid, out_err;
    logic [31:0] out_rdata, out_addr, out_wdata;
    logic [3:0]  out_rmask, out_wmask;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic        err;
    } cmp_t;

    // Reference model state
    cmp_t        q[$];
    cmp_t        exp_out;
    logic        exp_ov;
    logic [31:0] exp_daddr, exp_dwdata, m_baddr;
    logic [3:0]  exp_drm, exp_dwm;
    logic        m_busy;

    mem_req dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_load    (in_load),
        .in_store   (in_store),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_rdata  (out_rdata),
        .out_addr   (out_addr),
        .out_rmask  (out_rmask),
        .out_wmask  (out_wmask),
        .out_wdata  (out_wdata),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("dmem_addr",  dmem_addr,  exp_daddr);
        chk("dmem_rmask", {28'h0, dmem_rmask}, {28'h0, exp_drm});
        chk("dmem_wmask", {28'h0, dmem_wmask}, {28'h0, exp_dwm});
        chk("dmem_wdata", dmem_wdata, exp_dwdata);
        chk("out_valid",  {31'h0, out_valid}, {31'h0, exp_ov});
        chk("out_rdata",  out_rdata,  exp_out.rdata);
        chk("out_addr",   out_addr,   exp_out.addr);
        chk("out_rmask",  {28'h0, out_rmask}, {28'h0, exp_out.rm});
        chk("out_wmask",  {28'h0, out_wmask}, {28'h0, exp_out.wm});
        chk("out_wdata",  out_wdata,  exp_out.wd);
        chk("out_err",    {31'h0, out_err}, {31'h0, exp_out.err});
    endtask

    // Transaction-level model: one outstanding memory op, completions retire
    // in arrival order at one per cycle.
    task automatic model(input logic r, input logic v, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic rsp, input logic [31:0] rd);
        cmp_t        c;
        bit          acc, bad, legal_f3;
        int          nb, lanes;
        logic [63:0] dmask;
        if (!r) begin
            m_busy = 1'b0;
            q.delete();
            exp_daddr = 32'h0; exp_drm = 4'h0; exp_dwm = 4'h0; exp_dwdata = 32'h0;
            exp_ov = 1'b0; exp_out = '0;
            return;
        end
        acc = v && !(m_busy && !rsp);
        if (m_busy && rsp) begin
            c.addr = m_baddr; c.rdata = rd; c.rm = exp_drm; c.wm = exp_dwm;
            c.wd = exp_dwdata; c.err = 1'b0;
            q.push_back(c);
            m_busy = 1'b0;
            exp_daddr = 32'h0; exp_drm = 4'h0; exp_dwm = 4'h0; exp_dwdata = 32'h0;
        end
        if (acc) begin
            c = '0;
            c.addr = a;
            if (ld || st) begin
                legal_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                           (f3 == 3'd4) || (f3 == 3'd5);
                nb  = 1 << f3[1:0];
                bad = (ld && st) || !legal_f3 || ((a % nb) != 0);
                if (!bad) begin
                    lanes = ((1 << nb) - 1) << (a % 4);
                    dmask = (64'd1 << (8 * nb)) - 64'd1;
                    exp_daddr  = a & ~32'h3;
                    exp_drm    = ld ? lanes[3:0] : 4'h0;
                    exp_dwm    = st ? lanes[3:0] : 4'h0;
                    exp_dwdata = st ? ((wd & dmask[31:0]) << (8 * (a % 4))) : 32'h0;
                    m_baddr    = a;
                    m_busy     = 1'b1;
                end else begin
                    c.err = 1'b1;
                    q.push_back(c);
                end
            end else begin
                q.push_back(c);
            end
        end
        if (q.size() > 0) begin
            exp_out = q.pop_front();
            exp_ov  = 1'b1;
        end else begin
            exp_ov  = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic rsp, input logic [31:0] rd);
        @(negedge clk);
        check_outputs();
        rst = r; in_valid = v; in_load = ld; in_store = st; in_funct3 = f3;
        in_addr = a; in_wdata = wd; dmem_resp = rsp; dmem_rdata = rd;
        #1;
        chk("stall", {31'h0, stall}, {31'h0, m_busy & ~rsp});
        model(r, v, ld, st, f3, a, wd, rsp, rd);
    endtask

    task automatic idle(input logic rsp, input logic [31:0] rd);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, rsp, rd);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_funct3 = 3'b000; in_addr = 32'h0; in_wdata = 32'h0;
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        m_busy = 1'b0; exp_ov = 1'b0; exp_out = '0;
        exp_daddr = 32'h0; exp_drm = 4'h0; exp_dwm = 4'h0; exp_dwdata = 32'h0;
        m_baddr = 32'h0;
        repeat (2) @(posedge clk);

        // lw 0x100, response three cycles after accept
        step(1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0);
        idle(0, 32'h0);
        idle(0, 32'h0);
        idle(1, 32'hDEADBEEF);
        idle(0, 32'h0);

        // sb 0x203, response in the first visible cycle
        step(1, 1, 0, 1, 3'b000, 32'h203, 32'h000000AB, 0, 32'h0);
        idle(1, 32'h0);
        idle(0, 32'h0);

        // misaligned sh, then lh on upper half
        step(1, 1, 0, 1, 3'b001, 32'h301, 32'h1234, 0, 32'h0);
        idle(0, 32'h0);
        step(1, 1, 1, 0, 3'b001, 32'h302, 32'h0, 0, 32'h0);
        idle(1, 32'h87654321);
        idle(0, 32'h0);

        // back-to-back sw then lw accepted in the response cycle
        step(1, 1, 0, 1, 3'b010, 32'h400, 32'h11223344, 0, 32'h0);
        idle(0, 32'h0);
        step(1, 1, 1, 0, 3'b010, 32'h404, 32'h0, 1, 32'hCAFEF00D);
        idle(0, 32'h0);
        idle(1, 32'h12345678);
        idle(0, 32'h0);

        // reset during an outstanding lw; late response must be ignored
        step(1, 1, 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0);
        idle(0, 32'h0);
        step(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
        idle(0, 32'h0);
        idle(1, 32'hBAADF00D);
        idle(0, 32'h0);

        // stray response while idle
        idle(1, 32'h0BADC0DE);
        idle(0, 32'h0);

        // non-memory, load&store, illegal funct3, unsigned loads
        step(1, 1, 0, 0, 3'b000, 32'h600, 32'h0, 0, 32'h0);
        step(1, 1, 1, 1, 3'b010, 32'h604, 32'h0, 0, 32'h0);
        step(1, 1, 1, 0, 3'b011, 32'h608, 32'h0, 0, 32'h0);
        step(1, 1, 1, 0, 3'b100, 32'h60D, 32'h0, 0, 32'h0);
        idle(1, 32'hA5A5A5A5);
        step(1, 1, 1, 0, 3'b101, 32'h60E, 32'h0, 1, 32'h0);
        idle(1, 32'h5A5A5A5A);
        idle(0, 32'h0);

        // response colliding with immediate completions
        step(1, 1, 0, 1, 3'b001, 32'h702, 32'h0000BEEF, 0, 32'h0);
        step(1, 1, 0, 0, 3'b000, 32'h710, 32'h0, 1, 32'h77);
        step(1, 1, 1, 0, 3'b010, 32'h713, 32'h0, 0, 32'h0);
        idle(0, 32'h0);
        idle(0, 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, v, ld, st, rsp;
            logic [2:0]  f3;
            logic [31:0] a, wd, rd;
            r   = ($urandom_range(0, 59) != 0);
            v   = $urandom_range(0, 1);
            ld  = $urandom_range(0, 1);
            st  = $urandom_range(0, 1);
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            wd  = $urandom;
            rsp = ($urandom_range(0, 2) == 0);
            rd  = $urandom;
            step(r, v, ld, st, f3, a, wd, rsp, rd);
        end

        @(negedge clk);
        check_outputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req.md
MEM_REQ -- requirements
Module: mem_req

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-003 in_valid  in  1  instruction present from EX this cycle.
REQ-004 in_load, in_store  in  1 each  memory op class; both 0 = non-memory instruction; both 1 = illegal.
REQ-005 in_funct3  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; others illegal.
REQ-006 in_addr  in  32  byte address; in_wdata  in  32  store source (rs2 value).
REQ-007 dmem_addr  out  32  word-aligned request address ({addr[31:2],2'b00}).
REQ-008 dmem_rmask, dmem_wmask  out  4 each  byte-lane read/write enables; nonzero = request active.
REQ-009 dmem_wdata  out  32  lane-aligned store data; dmem_rdata  in  32  raw word; dmem_resp  in  1  completion strobe.
REQ-010 stall  out  1  combinational; 1 = upstream must not advance, in_* ignored.
REQ-011 out_valid  out  1  one-cycle completion pulse toward WB.
REQ-012 out_rdata (32, raw word), out_addr (32, original byte address), out_rmask/out_wmask (4), out_wdata (32), out_err (1): registered results for WB extraction and monitor.

Function
REQ-013 FSM states IDLE, REQ; accept = in_valid & ~stall.
REQ-014 stall SHALL equal (state==REQ) & ~dmem_resp; stall=0 in IDLE.
REQ-015 Accept of legal load/store in cycle T: dmem_* registered, visible from T+1; state->REQ.
REQ-016 Masks/addr/wdata SHALL hold stable from T+1 through the cycle dmem_resp=1 inclusive; cleared to 0 the next cycle unless a new request is accepted that same cycle.
REQ-017 dmem_resp sampled only in REQ; in that cycle out_* captured (out_rdata<=dmem_rdata), out_valid=1 next cycle, state->IDLE or stays REQ if new memory op accepted in the same cycle.
REQ-018 dmem_resp in the same cycle the request first becomes visible is legal; minimum load latency accept->out_valid = 2 cycles.
REQ-019 Write masks: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111; rmask uses the same rule for loads (unsigned variants identical to signed).
REQ-020 dmem_wdata: byte = wdata[7:0] << 8*addr[1:0]; half = wdata[15:0] << 16*addr[1]; word = wdata; other lanes 0; rmask=0 on stores, wmask=0 on loads.
REQ-021 Misaligned (half with addr[0]=1; word with addr[1:0]!=0), illegal funct3, or load&store: no dmem request; state stays IDLE; out_valid=1, out_err=1, masks 0 at T+1.
REQ-022 Non-memory accept: no request; out_valid=1 at T+1, out_err=0, masks 0, out_rdata=0.
REQ-023 out_addr/out_rmask/out_wmask/out_wdata SHALL equal the values of the request that produced the out_valid pulse.
REQ-024 out_valid SHALL be 0 in every cycle without a completion; at most one completion per cycle.
REQ-025 dmem_resp while IDLE SHALL be ignored (no out_valid, no state change).

Reset
REQ-026 rst=0 at an edge: state IDLE, dmem_addr/masks/wdata 0, out_valid 0, out_err 0, out_rdata/out_addr/out_wdata/out_*mask 0, stall 0 next cycle.
REQ-027 Reset during REQ abandons the request; a dmem_resp arriving after reset release SHALL be ignored per REQ-025.

Verification
REQ-028 lw addr 0x100, resp at T+3 with rdata 0xDEADBEEF -> dmem_rmask 1111 T+1..T+3, stall 1 at T+1..T+2, out_valid at T+4, out_rdata 0xDEADBEEF, out_addr 0x100.
REQ-029 sb addr 0x203, wdata 0x000000AB, resp at T+1 -> dmem_addr 0x200, wmask 1000, dmem_wdata 0xAB000000, out_valid at T+2, stall 0 throughout.
REQ-030 sh addr 0x301 -> no mask ever nonzero, out_valid T+1 with out_err 1; lh addr 0x302 -> rmask 1100.
REQ-031 Back-to-back: sw 0x400 resp at T+2 with lw 0x404 accepted at T+2 -> wmask 1111 T+1..T+2, rmask 1111 from T+3, two out_valid pulses at T+3 and after second resp.
REQ-032 rst=0 at T+2 during outstanding lw, dmem_resp at T+4 -> masks 0 from T+3, no out_valid, state IDLE.
REQ-033 dmem_resp pulsed while IDLE with no accept -> out_valid stays 0, all outputs unchanged.
